mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the MIPS pipeline. Executes MULT, MULTU, DIV and DIVU.
- Owns the architectural HI/LO registers and serves MFHI/MFLO, MTHI/MTLO.
- Drives busy_o. The hazard logic inverts it into the enable of the PC, IF/ID, ID/EX and EX/MEM pipeline registers, so the pipeline freezes while an operation iterates.
- All state updates on the falling clock edge, in step with the pipeline registers.

Parameters:
- N_BITS, 32, operand width; the product and HI:LO are 2*N_BITS wide.

Ports:
- clk  input  1  system clock; state updates on the negedge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  a valid mult/div instruction is in EX.
- op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data_i  input  N_BITS  multiplicand or dividend.
- rt_data_i  input  N_BITS  multiplier or divisor.
- wr_hi_i  input  1  MTHI write strobe.
- wr_lo_i  input  1  MTLO write strobe.
- wr_data_i  input  N_BITS  MTHI/MTLO data.
- hilo_sel_i  input  1  selects hilo_o: 0 = LO, 1 = HI.
- hilo_o  output  N_BITS  combinational read of the selected HI or LO.
- hi_o  output  N_BITS  HI register.
- lo_o  output  N_BITS  LO register.
- busy_o  output  1  stall request.
- done_o  output  1  one-cycle completion pulse.
- div_by_zero_o  output  1  pulses together with done_o when the divisor is 0.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE, iteration counter = 0.
  - HI, LO and the internal accumulator/remainder/operand registers = 0.
  - busy_o, done_o, div_by_zero_o = 0.
  - Reset mid-operation aborts the operation; HI/LO read 0 afterwards.
- States: IDLE, MUL, DIV, DONE.
- busy_o = (state==IDLE && start_i) || state==MUL || state==DIV. It is combinational so it stalls in the same cycle the instruction reaches EX.
- IDLE, start_i=1, at the edge:
  - Capture the operand magnitudes: absolute value for MULT/DIV, raw value for MULTU/DIVU.
  - Capture the result sign flags; clear the counter.
  - Go to MUL for ops 0x, DIV for ops 1x.
  - Exception: DIV/DIVU with rt_data_i==0 goes straight to DONE, flags div-by-zero, and leaves HI/LO unchanged.
- MUL: one shift-add step per edge on a 2*N_BITS accumulator. At the edge where counter==N_BITS-1:
  - Apply the sign fix: negate the 2*N_BITS result if the operand signs differ (signed ops only).
  - Write HI = upper half, LO = lower half; go to DONE.
- DIV: one restoring shift-subtract step per edge. At the edge where counter==N_BITS-1:
  - LO = quotient, negated if the operand signs differ (signed only).
  - HI = remainder, with the sign of the dividend (signed only).
  - Go to DONE.
- Signed-divide boundary: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
- Latency: busy_o is high for N_BITS+1 cycles (1 for divide-by-zero). It is then low for exactly one DONE cycle in which done_o=1, and the pipeline advances.
- DONE: return to IDLE at the next edge unconditionally. start_i during DONE is ignored; it belongs to the completing instruction.
- MTHI/MTLO:
  - wr_hi_i / wr_lo_i in IDLE or DONE write wr_data_i at the edge.
  - Ignored while in MUL or DIV.
  - A write in IDLE simultaneous with an accepted start is performed, then overwritten by the result.
- hilo_o, hi_o, lo_o reflect the registered HI/LO. During MUL/DIV they keep the previous values; intermediate state is never exposed.
- Signed operand 0x80000000: its magnitude is 0x80000000 treated as unsigned and must not overflow.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0x00000002 -> busy_o high 33 cycles, then done_o pulse; HI=0x00000001, LO=0xFFFFFFFE.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rt=0 with HI=0x11, LO=0x22 preloaded -> busy_o 1 cycle, done_o and div_by_zero_o pulse together, HI/LO unchanged.
- Start MULTU 7*9, assert reset low at iteration 10 -> busy_o, HI, LO = 0 immediately; after release, MULTU 3*4 -> LO=12 after 33 busy cycles.
- MTHI 0xA5A5A5A5, hilo_sel_i=1 -> hilo_o=0xA5A5A5A5; MTLO 0x1 asserted during MUL -> LO unaffected until the result is written.

Source files
------------

// File: rtl/mult_div_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_if
//  Brief    : EX-stage bundle between the pipeline and the multiply/divide unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface mult_div_if #(
    parameter int N_BITS = 32
);
    logic              start_i;
    logic [1:0]        op_i;
    logic [N_BITS-1:0] rs_data_i;
    logic [N_BITS-1:0] rt_data_i;
    logic              wr_hi_i;
    logic              wr_lo_i;
    logic [N_BITS-1:0] wr_data_i;
    logic              hilo_sel_i;
    logic [N_BITS-1:0] hilo_o;
    logic [N_BITS-1:0] hi_o;
    logic [N_BITS-1:0] lo_o;
    logic              busy_o;
    logic              done_o;
    logic              div_by_zero_o;

    modport master (
        output start_i, op_i, rs_data_i, rt_data_i,
        output wr_hi_i, wr_lo_i, wr_data_i, hilo_sel_i,
        input  hilo_o, hi_o, lo_o, busy_o, done_o, div_by_zero_o
    );

    modport slave (
        input  start_i, op_i, rs_data_i, rt_data_i,
        input  wr_hi_i, wr_lo_i, wr_data_i, hilo_sel_i,
        output hilo_o, hi_o, lo_o, busy_o, done_o, div_by_zero_o
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Brief    : Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; negedge-clocked.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int N_BITS = 32
) (
    input  logic       clk,
    input  logic       reset,
    mult_div_if.slave  bus
);
    localparam int                c_CW      = $clog2(N_BITS);
    localparam logic [c_CW-1:0]   c_LAST    = c_CW'(N_BITS - 1);
    localparam logic [c_CW-1:0]   c_CNT_ONE = c_CW'(1);
    localparam logic [1:0]        c_IDLE    = 2'd0;
    localparam logic [1:0]        c_MUL     = 2'd1;
    localparam logic [1:0]        c_DIV     = 2'd2;
    localparam logic [1:0]        c_DONE    = 2'd3;

    logic [1:0]          r_state;
    logic [c_CW-1:0]     r_cnt;
    logic [2*N_BITS-1:0] r_acc;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [N_BITS-1:0]   r_opb;      // multiplicand or divisor magnitude
    logic [N_BITS-1:0]   r_hi;
    logic [N_BITS-1:0]   r_lo;
    logic                r_neg;
    logic                r_rem_neg;
    logic                r_dbz;

    logic                w_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [N_BITS-1:0]   w_a_mag;
    logic [N_BITS-1:0]   w_b_mag;
    logic [N_BITS:0]     w_mul_sum;
    logic [2*N_BITS-1:0] w_mul_acc;
    logic [2*N_BITS-1:0] w_mul_res;
    logic [N_BITS:0]     w_div_shift;
    logic [N_BITS:0]     w_div_diff;
    logic [N_BITS-1:0]   w_div_rem;
    logic [2*N_BITS-1:0] w_div_acc;
    logic [N_BITS-1:0]   w_quot;
    logic [N_BITS-1:0]   w_lo_div;
    logic [N_BITS-1:0]   w_hi_div;
    logic                w_host_wr;

    // Magnitudes are unsigned N-bit values, so the most negative operand maps to itself.
    assign w_signed = ~bus.op_i[0];
    assign w_a_neg  = w_signed & bus.rs_data_i[N_BITS-1];
    assign w_b_neg  = w_signed & bus.rt_data_i[N_BITS-1];
    assign w_a_mag  = w_a_neg ? -bus.rs_data_i : bus.rs_data_i;
    assign w_b_mag  = w_b_neg ? -bus.rt_data_i : bus.rt_data_i;

    assign w_mul_sum = {1'b0, r_acc[2*N_BITS-1:N_BITS]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_acc = {w_mul_sum, r_acc[N_BITS-1:1]};
    assign w_mul_res = r_neg ? -w_mul_acc : w_mul_acc;

    // Restoring step: the remainder stays below the divisor, so N+1 bits suffice.
    assign w_div_shift = {r_acc[2*N_BITS-1:N_BITS], r_acc[N_BITS-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_rem   = w_div_diff[N_BITS] ? w_div_shift[N_BITS-1:0] : w_div_diff[N_BITS-1:0];
    assign w_div_acc   = {w_div_rem, r_acc[N_BITS-2:0], ~w_div_diff[N_BITS]};
    assign w_quot      = w_div_acc[N_BITS-1:0];
    assign w_lo_div    = r_neg ? -w_quot : w_quot;
    assign w_hi_div    = r_rem_neg ? -w_div_rem : w_div_rem;

    assign w_host_wr = (r_state == c_IDLE) || (r_state == c_DONE);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_dbz <= 1'b0;
            if (w_host_wr && bus.wr_hi_i) r_hi <= bus.wr_data_i;
            if (w_host_wr && bus.wr_lo_i) r_lo <= bus.wr_data_i;
            case (r_state)
                c_IDLE: begin
                    if (bus.start_i) begin
                        r_cnt     <= '0;
                        r_neg     <= w_a_neg ^ w_b_neg;
                        r_rem_neg <= w_a_neg;
                        r_opb     <= w_b_mag;
                        r_acc     <= {{N_BITS{1'b0}}, w_a_mag};
                        if (!bus.op_i[1]) begin
                            r_state <= c_MUL;
                        end else if (bus.rt_data_i == '0) begin
                            r_state <= c_DONE;
                            r_dbz   <= 1'b1;
                        end else begin
                            r_state <= c_DIV;
                        end
                    end
                end
                c_MUL: begin
                    r_acc <= w_mul_acc;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_LAST) begin
                        r_hi    <= w_mul_res[2*N_BITS-1:N_BITS];
                        r_lo    <= w_mul_res[N_BITS-1:0];
                        r_state <= c_DONE;
                    end
                end
                c_DIV: begin
                    r_acc <= w_div_acc;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_LAST) begin
                        r_hi    <= w_hi_div;
                        r_lo    <= w_lo_div;
                        r_state <= c_DONE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.busy_o        = ((r_state == c_IDLE) && bus.start_i) ||
                               (r_state == c_MUL) || (r_state == c_DIV);
    assign bus.done_o        = (r_state == c_DONE);
    assign bus.div_by_zero_o = r_dbz;
    assign bus.hi_o          = r_hi;
    assign bus.lo_o          = r_lo;
    assign bus.hilo_o        = bus.hilo_sel_i ? r_hi : r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Brief    : Scoreboard bench for mult_div_unit with an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    localparam int N = 32;

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dbz;
        int           busy;
    } exp_t;

    logic   clk   = 1'b0;
    logic   reset = 1'b0;
    int     n_checks = 0;
    int     n_errors = 0;
    exp_t   sb_q[$];
    exp_t   mon_e;
    int     mon_busy = 0;
    logic [N-1:0] m_hi = '0;
    logic [N-1:0] m_lo = '0;

    always #5 clk = ~clk;

    mult_div_if #(.N_BITS(N)) bus ();
    mult_div_unit #(.N_BITS(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands.
    function automatic exp_t ref_model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        e.hi = m_hi; e.lo = m_lo; e.dbz = 1'b0; e.busy = N + 1;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == '0) begin
                    e.dbz = 1'b1; e.busy = 1;
                end else if (op == 2'd2) begin
                    q = sa / sb; r = sa % sb;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input bit mid_wr);
        exp_t e;
        int   cyc;
        e = ref_model(op, a, b);
        sb_q.push_back(e);
        @(posedge clk);
        bus.start_i = 1'b1; bus.op_i = op; bus.rs_data_i = a; bus.rt_data_i = b;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            if (mid_wr && cyc == 5) begin
                check("lo_hold_busy", bus.lo_o, m_lo);
                bus.wr_lo_i = 1'b1; bus.wr_data_i = 32'h1;
            end else if (mid_wr && cyc == 6) begin
                bus.wr_lo_i = 1'b0;
            end
            if (mid_wr && cyc == 8) check("lo_after_mtlo_busy", bus.lo_o, m_lo);
        end while (!bus.done_o && cyc < 100);
        if (!bus.done_o) begin
            n_checks++; n_errors++;
            $display("FAIL done_timeout: got no done_o within %0d cycles, required done_o=1", cyc);
        end
        bus.start_i = 1'b0;
        m_hi = e.hi; m_lo = e.lo;
    endtask

    task automatic mt(input bit hi, input logic [N-1:0] d);
        @(posedge clk);
        bus.wr_hi_i = hi; bus.wr_lo_i = !hi; bus.wr_data_i = d;
        @(posedge clk);
        bus.wr_hi_i = 1'b0; bus.wr_lo_i = 1'b0;
        if (hi) m_hi = d; else m_lo = d;
        check(hi ? "mthi" : "mtlo", hi ? bus.hi_o : bus.lo_o, d);
    endtask

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: counts stall cycles and scores each completion against the queue.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                mon_busy = 0;
            end else begin
                if (bus.busy_o) mon_busy++;
                if (bus.done_o) begin
                    if (sb_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL unexpected_done: got done_o=1, required no completion");
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("sb_hi", bus.hi_o, mon_e.hi);
                        check("sb_lo", bus.lo_o, mon_e.lo);
                        check("sb_dbz", bus.div_by_zero_o, mon_e.dbz);
                        check("sb_busy_cycles", mon_busy, mon_e.busy);
                    end
                    mon_busy = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got no end of test, required completion before time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        bus.start_i = 1'b0; bus.op_i = 2'd0; bus.rs_data_i = '0; bus.rt_data_i = '0;
        bus.wr_hi_i = 1'b0; bus.wr_lo_i = 1'b0; bus.wr_data_i = '0; bus.hilo_sel_i = 1'b0;
        #2;
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_dbz", bus.div_by_zero_o, 0);
        check("rst_hi", bus.hi_o, 0);
        check("rst_lo", bus.lo_o, 0);
        @(posedge clk);
        reset = 1'b1;

        run_op(2'd1, 32'hFFFF_FFFF, 32'h2, 1'b0);
        check("multu_hi", bus.hi_o, 32'h1);
        check("multu_lo", bus.lo_o, 32'hFFFF_FFFE);
        run_op(2'd0, 32'hFFFF_FFFD, 32'h5, 1'b0);
        check("mult_neg_hi", bus.hi_o, 32'hFFFF_FFFF);
        check("mult_neg_lo", bus.lo_o, 32'hFFFF_FFF1);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        check("mult_min_hi", bus.hi_o, 32'h4000_0000);
        check("mult_min_lo", bus.lo_o, 32'h0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'h2, 1'b0);
        check("div_neg_lo", bus.lo_o, 32'hFFFF_FFFD);
        check("div_neg_hi", bus.hi_o, 32'hFFFF_FFFF);
        run_op(2'd3, 32'd100, 32'd7, 1'b0);
        check("divu_lo", bus.lo_o, 32'd14);
        check("divu_hi", bus.hi_o, 32'd2);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_wrap_lo", bus.lo_o, 32'h8000_0000);
        check("div_wrap_hi", bus.hi_o, 32'h0);

        mt(1'b1, 32'h11);
        mt(1'b0, 32'h22);
        run_op(2'd3, 32'd1234, 32'd0, 1'b0);
        check("dbz_hi_kept", bus.hi_o, 32'h11);
        check("dbz_lo_kept", bus.lo_o, 32'h22);

        mt(1'b1, 32'hA5A5_A5A5);
        bus.hilo_sel_i = 1'b1;
        #1 check("hilo_sel_hi", bus.hilo_o, 32'hA5A5_A5A5);
        bus.hilo_sel_i = 1'b0;
        #1 check("hilo_sel_lo", bus.hilo_o, m_lo);

        // Abort a MULTU mid-iteration with reset; nothing is queued for it.
        @(posedge clk);
        bus.start_i = 1'b1; bus.op_i = 2'd1; bus.rs_data_i = 32'd7; bus.rt_data_i = 32'd9;
        repeat (11) @(posedge clk);
        reset = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check("abort_busy", bus.busy_o, 0);
        check("abort_done", bus.done_o, 0);
        check("abort_hi", bus.hi_o, 0);
        check("abort_lo", bus.lo_o, 0);
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        reset = 1'b1;
        run_op(2'd1, 32'd3, 32'd4, 1'b0);
        check("post_abort_lo", bus.lo_o, 32'd12);

        for (int i = 0; i < 20; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
